prod_accum: RTL and testbench
=============================

PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 The module SHALL have a parameter R_WIDTH, default 43, giving the product input width (25x18 multiplier result).
REQ-002 The module SHALL have a parameter ACC_WIDTH, default 48, giving the accumulator and sum width; ACC_WIDTH >= R_WIDTH.
REQ-003 The module SHALL have a parameter LEN_WIDTH, default 16, giving the vector-length field width.
REQ-004 The module SHALL have a port clk_i, input, 1 bit: clock, all state on rising edge.
REQ-005 The module SHALL have a port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The module SHALL have a port start_i, input, 1 bit: start-of-vector pulse.
REQ-007 The module SHALL have a port len_i, input, LEN_WIDTH bits: number of products in the vector, sampled with start_i.
REQ-008 The module SHALL have a port prod_i, input, R_WIDTH bits: unsigned product from the registered multiplier stage.
REQ-009 The module SHALL have a port prod_valid_i, input, 1 bit: prod_i valid this cycle (no backpressure toward the multiplier).
REQ-010 The module SHALL have a port busy_o, output, 1 bit: high in ACCUM and HOLD.
REQ-011 The module SHALL have a port sum_o, output, ACC_WIDTH bits: accumulated sum.
REQ-012 The module SHALL have a port sum_valid_o, output, 1 bit: sum_o valid.
REQ-013 The module SHALL have a port sum_ready_i, input, 1 bit: consumer accepts sum_o.
REQ-014 The module SHALL have a port ovf_o, output, 1 bit: sticky carry-out of the current vector, valid with sum_valid_o.
REQ-015 The module SHALL have a port drop_o, output, 1 bit: one-cycle pulse when prod_valid_i is high outside ACCUM.

Function
REQ-016 The FSM SHALL have states IDLE, ACCUM and HOLD.
REQ-017 In IDLE, start_i with len_i != 0 SHALL clear the accumulator, cnt and ovf, latch len_i and move to ACCUM next cycle.
REQ-018 In IDLE, start_i with len_i == 0 SHALL clear the accumulator and ovf and move to HOLD, so sum_valid_o=1 with sum_o=0 the next cycle.
REQ-019 start_i SHALL be ignored in ACCUM and HOLD.
REQ-020 In ACCUM, each cycle with prod_valid_i=1 SHALL add zero-extended prod_i to acc modulo 2^ACC_WIDTH, increment cnt, and OR the carry-out into ovf.
REQ-021 Cycles with prod_valid_i=0 in ACCUM SHALL leave acc and cnt unchanged; gaps of any length SHALL be legal.
REQ-022 The product accepted when cnt == len-1 SHALL be the last one: the FSM SHALL enter HOLD and assert sum_valid_o on the next cycle, i.e. one cycle of latency from the last product to the result.
REQ-023 In HOLD, sum_o, ovf_o and sum_valid_o SHALL stay stable until sum_valid_o && sum_ready_i, then the FSM SHALL return to IDLE on the next cycle.
REQ-024 sum_ready_i SHALL be ignored while sum_valid_o=0.
REQ-025 prod_valid_i in IDLE or HOLD SHALL not alter acc; drop_o SHALL pulse on the following cycle.
REQ-026 start_i in the same cycle as the HOLD handshake SHALL be ignored; a new start SHALL be accepted from IDLE only.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 While rst_i is high, the FSM SHALL be in IDLE and acc, cnt, len, sum_o, sum_valid_o, ovf_o, drop_o and busy_o SHALL be 0, regardless of the clock.
REQ-029 Reset asserted mid-vector SHALL abort the vector with no partial result emitted; the first start_i after deassertion SHALL begin normally.

Structure
REQ-030 A shared package SHALL hold the state enum type (IDLE/ACCUM/HOLD) and the default width constants R_WIDTH=43, ACC_WIDTH=48 and LEN_WIDTH=16.
REQ-031 The module SHALL be a single module with no sub-modules; the adder, counter and FSM SHALL be inline.

Verification
REQ-032 The bench SHALL cover basic accumulation: start with len=3, products 2, 3, 5 back-to-back -> sum_o=10, ovf_o=0, sum_valid_o high 1 cycle after the 3rd product.
REQ-033 The bench SHALL cover gaps and backpressure: len=2, products 7 and 9 separated by 4 idle cycles, sum_ready_i held low 5 cycles -> sum_o=16 held stable, then IDLE one cycle after the handshake.
REQ-034 The bench SHALL cover overflow: len=33, all products 2^43-1 -> sum_o=2^43-33, ovf_o=1; the same test with len=32 -> sum_o=2^48-32, ovf_o=0.
REQ-035 The bench SHALL cover zero length: start with len=0 -> sum_valid_o=1 with sum_o=0 on the next cycle, no products consumed.
REQ-036 The bench SHALL cover reset and stray inputs: rst_i pulsed after 2 of 4 products -> no sum_valid_o, all outputs 0; prod_valid_i=1 in IDLE -> drop_o pulse, next vector (len=1, product 4) -> sum_o=4.

Source files
------------

// File: rtl/prod_accum_pkg.sv
// Shared types and default widths for the product accumulator.
package prod_accum_pkg;

  localparam int R_WIDTH_DEFAULT   = 43;
  localparam int ACC_WIDTH_DEFAULT = 48;
  localparam int LEN_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/prod_accum.sv
// Vector accumulator: sums len_i unsigned products after a start pulse and
// holds the result with a sticky carry flag until the consumer accepts it.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int R_WIDTH   = R_WIDTH_DEFAULT,
  parameter int ACC_WIDTH = ACC_WIDTH_DEFAULT,
  parameter int LEN_WIDTH = LEN_WIDTH_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic [R_WIDTH-1:0]   prod_i,
  input  logic                 prod_valid_i,
  output logic                 busy_o,
  output logic [ACC_WIDTH-1:0] sum_o,
  output logic                 sum_valid_o,
  input  logic                 sum_ready_i,
  output logic                 ovf_o,
  output logic                 drop_o
);

  state_t               state_reg, state_next;
  logic [ACC_WIDTH-1:0] acc_reg, acc_next;
  logic [LEN_WIDTH-1:0] cnt_reg, cnt_next;
  logic [LEN_WIDTH-1:0] len_reg, len_next;
  logic                 ovf_reg, ovf_next;
  logic                 sum_valid_reg;
  logic                 busy_reg;
  logic                 drop_reg;
  logic [ACC_WIDTH:0]   sum_ext;
  logic [LEN_WIDTH-1:0] cnt_inc;

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    len_next   = len_reg;
    ovf_next   = ovf_reg;
    // Extra top bit captures the carry-out of the modulo-2^ACC_WIDTH add.
    sum_ext    = {1'b0, acc_reg} + {{(ACC_WIDTH - R_WIDTH + 1){1'b0}}, prod_i};
    cnt_inc    = cnt_reg + 1'b1;

    case (state_reg)
      IDLE: begin
        if (start_i) begin
          acc_next   = '0;
          cnt_next   = '0;
          ovf_next   = 1'b0;
          len_next   = len_i;
          state_next = (len_i == '0) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (prod_valid_i) begin
          acc_next = sum_ext[ACC_WIDTH-1:0];
          ovf_next = ovf_reg | sum_ext[ACC_WIDTH];
          cnt_next = cnt_inc;
          if (cnt_inc == len_reg) begin
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        // sum_valid_o is always high in HOLD, so ready alone completes it.
        if (sum_ready_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      len_reg       <= '0;
      ovf_reg       <= 1'b0;
      sum_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      drop_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      len_reg       <= len_next;
      ovf_reg       <= ovf_next;
      // Status flags are registered from the next state so they align with it.
      sum_valid_reg <= (state_next == HOLD);
      busy_reg      <= (state_next != IDLE);
      drop_reg      <= prod_valid_i && (state_reg != ACCUM);
    end
  end

  assign sum_o       = acc_reg;
  assign ovf_o       = ovf_reg;
  assign sum_valid_o = sum_valid_reg;
  assign busy_o      = busy_reg;
  assign drop_o      = drop_reg;

endmodule

// File: tb/tb_prod_accum.sv
// Randomized self-checking bench for prod_accum with an arithmetic sum model.
module tb_prod_accum;

  localparam int RW = 43;
  localparam int AW = 48;
  localparam int LW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          start_i = 1'b0;
  logic [LW-1:0] len_i = '0;
  logic [RW-1:0] prod_i = '0;
  logic          prod_valid_i = 1'b0;
  logic          busy_o;
  logic [AW-1:0] sum_o;
  logic          sum_valid_o;
  logic          sum_ready_i = 1'b0;
  logic          ovf_o;
  logic          drop_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  longint unsigned prod_q[$];

  prod_accum #(.R_WIDTH(RW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .len_i        (len_i),
    .prod_i       (prod_i),
    .prod_valid_i (prod_valid_i),
    .busy_o       (busy_o),
    .sum_o        (sum_o),
    .sum_valid_o  (sum_valid_o),
    .sum_ready_i  (sum_ready_i),
    .ovf_o        (ovf_o),
    .drop_o       (drop_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Runs one vector using the products in prod_q; expected sum is the plain
  // integer total reduced modulo 2^AW, with overflow meaning total >= 2^AW.
  task automatic run_vector(input int gap_lo, input int gap_hi, input int ready_delay);
    longint unsigned total = 0;
    longint unsigned exp_sum;
    logic            exp_ovf;
    int              n = prod_q.size();
    int              gap;
    logic            stray;

    start_i = 1'b1;
    len_i   = LW'(n);
    step();
    start_i = 1'b0;

    for (int i = 0; i < n; i++) begin
      gap = (i == 0) ? 0 : int'($urandom_range(gap_hi, gap_lo));
      repeat (gap) begin
        prod_valid_i = 1'b0;
        start_i      = 1'($urandom % 2);
        len_i        = LW'($urandom_range(9, 0));
        step();
        check("valid_during_gap", 64'(sum_valid_o), 64'd0);
      end
      start_i      = 1'b0;
      prod_valid_i = 1'b1;
      prod_i       = RW'(prod_q[i]);
      total       += prod_q[i];
      if (i == n - 1 && n > 0) check("valid_before_last", 64'(sum_valid_o), (i == 0) ? 64'd0 : 64'd0);
      step();
    end
    prod_valid_i = 1'b0;

    exp_sum = total & ((64'd1 << AW) - 64'd1);
    exp_ovf = (total >> AW) != 0;
    $display("vector len=%0d total=0x%0h -> sum=0x%0h ovf=%0b", n, total, sum_o, ovf_o);
    check("sum_valid", 64'(sum_valid_o), 64'd1);
    check("sum", 64'(sum_o), exp_sum);
    check("ovf", 64'(ovf_o), 64'(exp_ovf));
    check("busy_hold", 64'(busy_o), 64'd1);

    sum_ready_i = 1'b0;
    for (int d = 0; d < ready_delay; d++) begin
      stray        = 1'($urandom % 2);
      prod_valid_i = stray;
      prod_i       = RW'($urandom);
      step();
      check("hold_sum", 64'(sum_o), exp_sum);
      check("hold_valid", 64'(sum_valid_o), 64'd1);
      check("hold_ovf", 64'(ovf_o), 64'(exp_ovf));
      check("hold_drop", 64'(drop_o), 64'(stray));
    end
    prod_valid_i = 1'b0;

    // Start coinciding with the handshake must be ignored.
    sum_ready_i = 1'b1;
    start_i     = 1'b1;
    len_i       = LW'(3);
    step();
    sum_ready_i = 1'b0;
    start_i     = 1'b0;
    check("idle_valid", 64'(sum_valid_o), 64'd0);
    check("idle_busy", 64'(busy_o), 64'd0);
    step();
    check("still_idle", 64'(busy_o), 64'd0);
    prod_q.delete();
  endtask

  initial begin
    logic [63:0] r;

    #1 rst_i = 1'b1;
    #2;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_valid", 64'(sum_valid_o), 64'd0);
    check("rst_sum", 64'(sum_o), 64'd0);
    check("rst_ovf", 64'(ovf_o), 64'd0);
    check("rst_drop", 64'(drop_o), 64'd0);
    step();
    step();
    rst_i = 1'b0;
    step();

    // Basic back-to-back accumulation.
    prod_q = '{64'd2, 64'd3, 64'd5};
    run_vector(0, 0, 0);

    // Gaps of four cycles and five cycles of backpressure.
    prod_q = '{64'd7, 64'd9};
    run_vector(4, 4, 5);

    // Overflow boundary: 33 maximal products carry out, 32 do not.
    repeat (33) prod_q.push_back((64'd1 << RW) - 64'd1);
    run_vector(0, 0, 1);
    repeat (32) prod_q.push_back((64'd1 << RW) - 64'd1);
    run_vector(0, 2, 1);

    // Zero length goes straight to a zero result.
    start_i = 1'b1;
    len_i   = '0;
    step();
    start_i = 1'b0;
    check("zlen_valid", 64'(sum_valid_o), 64'd1);
    check("zlen_sum", 64'(sum_o), 64'd0);
    check("zlen_ovf", 64'(ovf_o), 64'd0);
    sum_ready_i = 1'b1;
    step();
    sum_ready_i = 1'b0;
    check("zlen_done", 64'(busy_o), 64'd0);

    // Reset in the middle of a vector aborts it without a result.
    start_i = 1'b1;
    len_i   = LW'(4);
    step();
    start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      prod_valid_i = 1'b1;
      prod_i       = RW'(i + 5);
      step();
    end
    prod_valid_i = 1'b0;
    rst_i = 1'b1;
    #2;
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    check("mid_rst_sum", 64'(sum_o), 64'd0);
    check("mid_rst_valid", 64'(sum_valid_o), 64'd0);
    check("mid_rst_ovf", 64'(ovf_o), 64'd0);
    step();
    rst_i = 1'b0;
    step();
    check("post_rst_valid", 64'(sum_valid_o), 64'd0);

    // Stray product in IDLE produces a one-cycle drop pulse.
    prod_valid_i = 1'b1;
    prod_i       = RW'(99);
    step();
    prod_valid_i = 1'b0;
    check("drop_pulse", 64'(drop_o), 64'd1);
    check("drop_busy", 64'(busy_o), 64'd0);
    step();
    check("drop_clear", 64'(drop_o), 64'd0);

    prod_q = '{64'd4};
    run_vector(0, 0, 0);

    // Random vectors with random gaps, backpressure and stray inputs.
    for (int v = 0; v < 20; v++) begin
      int len = int'($urandom_range(8, 1));
      for (int i = 0; i < len; i++) begin
        r = {$urandom, $urandom};
        prod_q.push_back((v % 4 == 0) ? ((64'd1 << RW) - 64'd1 - 64'(r[3:0])) : 64'(r[RW-1:0]));
      end
      run_vector(0, 3, int'($urandom_range(3, 0)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
